// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART receive path:
//               FIFO entry width helper, default buffer geometry, the
//               character-timeout limit and the frame-format encodings used
//               by the receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Default buffer geometry
    localparam int unsigned c_DATA_BITS_DEFAULT   = 8;
    localparam int unsigned c_DEPTH_DEFAULT       = 16;
    localparam int unsigned c_ADDR_WIDTH_DEFAULT  = 4;
    localparam int unsigned c_ALMOST_FULL_DEFAULT = 12;

    // Character timeout: 4 characters x 10 bit periods, 16 samples per bit
    localparam int unsigned c_OVERSAMP_RATE_DEFAULT = 16;
    localparam int unsigned c_TIMEOUT_BITS_DEFAULT  = 40;
    localparam int unsigned c_TIMEOUT_LIMIT =
        c_TIMEOUT_BITS_DEFAULT * c_OVERSAMP_RATE_DEFAULT;

    // Frame-format encodings shared with the receiver
    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2
    } parity_e;

    typedef enum logic [1:0] {
        STOP_1    = 2'd0,
        STOP_1_5  = 2'd1,
        STOP_2    = 2'd2
    } stop_bits_e;

    // One FIFO entry holds the data byte plus its parity-error flag
    function automatic int unsigned entry_width(input int unsigned data_bits);
        return data_bits + 1;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo_mem
// Description : DEPTH x WIDTH register array, synchronous write port and
//               asynchronous read port. Contents are not reset.
// Ports       : clk_i      - system clock
//               wr_en_i    - write strobe
//               wr_addr_i  - write address
//               wr_data_i  - write data
//               rd_addr_i  - read address
//               rd_data_o  - read data (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo_mem #(
    parameter int unsigned WIDTH      = 9,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [WIDTH-1:0]      rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule : uart_fifo_mem
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Receive FIFO behind the UART receiver. Stores {parity_err,
//               data} per byte, presents the head entry first-word-fall-
//               through, and raises overrun and character-timeout interrupts.
// Ports       : clk_i, reset_i (async, active-high)
//               clk_sample_i     - 16x oversample enable (timeout time base)
//               wr_data_i/wr_valid_i/parity_error_i - byte from receiver
//               rd_en_i          - pop head entry
//               rd_data_o/rd_parity_err_o - head entry (0 when empty)
//               empty_o/full_o/almost_full_o/count_o - occupancy status
//               int_overrun_o/int_timeout_o - sticky interrupts
//               int_clear_n_i    - active-low clear of both interrupts
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BIT_NUM      = c_DATA_BITS_DEFAULT,
    parameter int unsigned DEPTH             = c_DEPTH_DEFAULT,
    parameter int unsigned ADDR_WIDTH        = c_ADDR_WIDTH_DEFAULT,
    parameter int unsigned ALMOST_FULL_LEVEL = c_ALMOST_FULL_DEFAULT,
    parameter int unsigned OVERSAMP_RATE     = c_OVERSAMP_RATE_DEFAULT,
    parameter int unsigned TIMEOUT_BITS      = c_TIMEOUT_BITS_DEFAULT
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    clk_sample_i,
    input  logic [DATA_BIT_NUM-1:0] wr_data_i,
    input  logic                    wr_valid_i,
    input  logic                    parity_error_i,
    input  logic                    rd_en_i,
    output logic [DATA_BIT_NUM-1:0] rd_data_o,
    output logic                    rd_parity_err_o,
    output logic                    empty_o,
    output logic                    full_o,
    output logic                    almost_full_o,
    output logic [ADDR_WIDTH:0]     count_o,
    output logic                    int_overrun_o,
    output logic                    int_timeout_o,
    input  logic                    int_clear_n_i
);

    localparam int unsigned c_ENTRY_W       = entry_width(DATA_BIT_NUM);
    localparam int unsigned c_PTR_W         = ADDR_WIDTH + 1;
    localparam int unsigned c_TIMEOUT_LIMIT = TIMEOUT_BITS * OVERSAMP_RATE;
    localparam int unsigned c_TO_W          = $clog2(c_TIMEOUT_LIMIT + 1);

    logic [c_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_PTR_W-1:0]   count_q, count_d;
    logic                 empty_q, empty_d;
    logic                 full_q, full_d;
    logic                 almost_full_q, almost_full_d;
    logic                 overrun_q, overrun_d;
    logic                 timeout_q, timeout_d;
    logic [c_TO_W-1:0]    to_cnt_q, to_cnt_d;

    logic                 w_do_rd;
    logic                 w_do_wr;
    logic                 w_ovr_set;
    logic                 w_to_set;
    logic [c_ENTRY_W-1:0] w_head;

    uart_fifo_mem #(
        .WIDTH      (c_ENTRY_W),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk_i      (clk_i),
        .wr_en_i    (w_do_wr),
        .wr_addr_i  (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data_i  ({parity_error_i, wr_data_i}),
        .rd_addr_i  (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data_o  (w_head)
    );

    always_comb begin
        // A read while full frees a slot in the same edge, so the write
        // is accepted rather than counted as an overrun.
        w_do_rd   = rd_en_i && !empty_q;
        w_do_wr   = wr_valid_i && (!full_q || w_do_rd);
        w_ovr_set = wr_valid_i && full_q && !w_do_rd;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_do_wr) wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
        if (w_do_rd) rd_ptr_d = rd_ptr_q + c_PTR_W'(1);

        // Status is derived from the next pointers so it lines up with them
        count_d       = wr_ptr_d - rd_ptr_d;
        empty_d       = (count_d == '0);
        full_d        = (count_d == c_PTR_W'(DEPTH));
        almost_full_d = (count_d >= c_PTR_W'(ALMOST_FULL_LEVEL));

        // Timeout fires on the tick that would take the counter past
        // LIMIT-1; the counter then parks at LIMIT so it fires only once
        // per idle stretch, even after the interrupt is cleared.
        w_to_set = clk_sample_i && !empty_q && !w_do_wr && !w_do_rd &&
                   (to_cnt_q == c_TO_W'(c_TIMEOUT_LIMIT - 1));

        to_cnt_d = to_cnt_q;
        if (w_do_wr || w_do_rd || empty_q) begin
            to_cnt_d = '0;
        end else if (clk_sample_i && (to_cnt_q != c_TO_W'(c_TIMEOUT_LIMIT))) begin
            to_cnt_d = to_cnt_q + c_TO_W'(1);
        end

        // Set events take priority over clear
        overrun_d = overrun_q;
        if (w_ovr_set)           overrun_d = 1'b1;
        else if (!int_clear_n_i) overrun_d = 1'b0;

        timeout_d = timeout_q;
        if (w_to_set)                      timeout_d = 1'b1;
        else if (!int_clear_n_i || w_do_rd) timeout_d = 1'b0;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            empty_q       <= 1'b1;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_q     <= 1'b0;
            to_cnt_q      <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            empty_q       <= empty_d;
            full_q        <= full_d;
            almost_full_q <= almost_full_d;
            overrun_q     <= overrun_d;
            timeout_q     <= timeout_d;
            to_cnt_q      <= to_cnt_d;
        end
    end

    // Storage is not reset, so mask the head entry while empty
    assign {rd_parity_err_o, rd_data_o} = empty_q ? '0 : w_head;
    assign empty_o       = empty_q;
    assign full_o        = full_q;
    assign almost_full_o = almost_full_q;
    assign count_o       = count_q;
    assign int_overrun_o = overrun_q;
    assign int_timeout_o = timeout_q;

endmodule : uart_rx_fifo
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer directly downstream of uart_rx_op. Captures every byte and its parity-error status from the receiver's single-cycle valid strobe into a circular FIFO. Presents them to the host/bus side with first-word-fall-through reads. Generates level, overrun and character-timeout interrupts; the timeout is timed off the same 16x oversample enable (clk16_en from clk_divider) that drives the receiver.

Parameters:
DATA_BIT_NUM, 8, data width per entry (matches uart_rx_op DATA_BIT_NUM, 5..8)
DEPTH, 16, number of entries, power of two
ADDR_WIDTH, 4, log2(DEPTH)
ALMOST_FULL_LEVEL, 12, almost_full_o asserts when count >= this value
OVERSAMP_RATE, 16, sample ticks per bit period
TIMEOUT_BITS, 40, idle bit periods (4 chars x 10 bits) before timeout fires

Ports:
clk_i  in  1  system clock (100 MHz)
reset_i  in  1  asynchronous, active-high reset
clk_sample_i  in  1  oversample enable, one clk_i cycle wide
wr_data_i  in  DATA_BIT_NUM  byte from uart_rx_op data_out_o
wr_valid_i  in  1  single-cycle strobe from data_out_valid_o
parity_error_i  in  1  parity status for the byte, sampled with wr_valid_i
rd_en_i  in  1  pop head entry
rd_data_o  out  DATA_BIT_NUM  head entry data (FWFT)
rd_parity_err_o  out  1  parity flag stored with head entry
empty_o  out  1  FIFO empty
full_o  out  1  FIFO full
almost_full_o  out  1  count >= ALMOST_FULL_LEVEL
count_o  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
int_overrun_o  out  1  sticky: write attempted while full
int_timeout_o  out  1  sticky: data waiting, no activity for TIMEOUT_BITS
int_clear_n_i  in  1  synchronous active-low clear of both sticky interrupts

Behaviour:
- Reset values: empty_o=1; full_o=0; almost_full_o=0; count_o=0; rd_data_o=0; rd_parity_err_o=0; int_overrun_o=0; int_timeout_o=0. Pointers and timeout counter are 0. Storage contents are not reset.
- Storage: DEPTH x (DATA_BIT_NUM+1) array holding {parity_err, data}. Write and read pointers are ADDR_WIDTH+1 bits; the MSB distinguishes full from empty.
- Write:
  - On a clk_i edge with wr_valid_i=1 and not full, store {parity_error_i, wr_data_i} at wr_ptr and increment wr_ptr.
  - Wrap from DEPTH-1 to 0 is natural.
- Read (FWFT):
  - rd_data_o and rd_parity_err_o continuously show the entry at rd_ptr whenever empty_o=0.
  - rd_en_i=1 with empty_o=0 increments rd_ptr at that edge.
  - rd_en_i while empty is ignored.
- Latency:
  - A byte written at edge N gives empty_o=0, valid rd_data_o and updated count_o after edge N (visible in cycle N+1).
  - Flags are registered from the next pointer values, so there is no extra lag.
- Simultaneous wr_valid_i and rd_en_i:
  - Not empty: both occur; count unchanged.
  - Full: both occur, no overrun, full_o stays 1.
  - Empty: write only; the read is ignored.
- Overflow: wr_valid_i while full and no concurrent read drops the byte, leaves pointers unchanged and sets int_overrun_o.
- Timeout:
  - A counter of clk_sample_i ticks runs while empty_o=0.
  - The counter resets to 0 on any accepted write, any pop, or when empty.
  - When it reaches TIMEOUT_BITS*OVERSAMP_RATE-1 on a tick, int_timeout_o sets and the counter saturates.
  - int_timeout_o also clears on any pop.
- Interrupt clear: int_clear_n_i=0 clears both sticky bits at the next edge. A set event in the same cycle wins.
- Reset mid-operation: asynchronous return to reset values. Buffered data is discarded and a partial write strobe is lost.

Decomposition:
- Shared package (uart_pkg) holds:
  - entry width function DATA_BIT_NUM+1;
  - default DEPTH/ALMOST_FULL_LEVEL constants;
  - timeout limit constant TIMEOUT_BITS*OVERSAMP_RATE;
  - parity/stop-bit encodings already used by uart_rx_op.
- One natural sub-module: uart_fifo_mem, a DEPTH x width register array with a synchronous write port and an asynchronous read port. Pointer/flag/interrupt logic stays in uart_rx_fifo.

Test Plan:
1. Reset, then three frames 0x55, 0x1E, 0x70 via uart_rx_op at 115200 baud, no reads. Expect count_o=3, empty_o=0, rd_data_o=0x55. Pop three times: 0x1E, 0x70, then empty_o=1, count_o=0.
2. Write 16 bytes 0x00..0x0F directly. Expect almost_full_o at count 12 and full_o at 16. A 17th write 0xAA is dropped and int_overrun_o=1. Drain: 0x00..0x0F in order, with 0xAA absent.
3. When full, assert wr_valid_i (0x99) and rd_en_i in the same cycle. Expect no overrun and count_o=16. 0x99 is read last, after 0x01..0x0F.
4. Write 0x42 with parity_error_i=1, then 0x43 with 0. Expect rd_parity_err_o=1 for 0x42 and 0 for 0x43.
5. Write one byte, then idle with clk16_en. Expect int_timeout_o=1 exactly 640 sample ticks after the write. int_clear_n_i low for one cycle returns it to 0. A pop also clears it.
6. Assert reset_i asynchronously (mid-clock) with count_o=5. Expect immediate empty_o=1, count_o=0 and interrupts 0. After release, a write of 0x3C reads back 0x3C.
